// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte sources.
// It grants one requester, launches the byte with TX_DV, then follows DONE until the frame ends.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 16
) (
   input  logic                 SER_CLK,
   input  logic                 RST,
   input  logic [NUM_REQ-1:0]   REQ_VALID,
   input  logic [8*NUM_REQ-1:0] REQ_BYTE,
   output logic [NUM_REQ-1:0]   REQ_ACK,
   output logic                 TX_DV,
   output logic [7:0]           TX_BYTE,
   input  logic                 TX_DONE,
   output logic [2:0]           GRANT_ID,
   output logic                 BUSY,
   output logic                 ERR
);

   localparam int              CW       = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(START_TIMEOUT - 1);
   localparam logic [3:0]      NREQ     = 4'(NUM_REQ);
   localparam logic [2:0]      LAST_ID  = 3'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t             state, next_state;
   logic [2:0]         ptr, next_ptr;
   logic [CW-1:0]      cnt, next_cnt;
   logic [NUM_REQ-1:0] next_ack;
   logic               next_dv;
   logic               next_err;
   logic [7:0]         next_byte;
   logic [2:0]         next_grant;

   logic [7:0]         valid_pad;
   logic [63:0]        byte_pad;
   logic [7:0]         ack_pad;
   logic               found;
   logic [2:0]         win;
   logic [3:0]         probe;

   assign valid_pad = 8'(REQ_VALID);
   assign byte_pad  = 64'(REQ_BYTE);
   assign ack_pad   = 8'b1 << win;

   // Walk the slots from farthest to nearest so the slot closest to ptr is the last one written.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      probe = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         probe = {1'b0, ptr} + 4'(k);
         if (probe >= NREQ) begin
            probe = probe - NREQ;
         end
         if (valid_pad[probe[2:0]]) begin
            found = 1'b1;
            win   = probe[2:0];
         end
      end
   end

   always_comb begin
      next_state = state;
      next_ptr   = ptr;
      next_cnt   = cnt;
      next_ack   = '0;
      next_dv    = 1'b0;
      next_err   = 1'b0;
      next_byte  = TX_BYTE;
      next_grant = GRANT_ID;
      case (state)
         IDLE: begin
            if (TX_DONE && found) begin
               next_byte  = byte_pad[{win, 3'b000} +: 8];
               next_grant = win;
               next_ack   = ack_pad[NUM_REQ-1:0];
               next_ptr   = (win == LAST_ID) ? 3'd0 : win + 3'd1;
               next_state = LAUNCH;
            end
         end
         LAUNCH: begin
            next_dv    = 1'b1;
            next_cnt   = '0;
            next_state = WAIT_BUSY;
         end
         // TX_DV has to drop as soon as DONE falls, otherwise the UART re-latches it after the frame.
         WAIT_BUSY: begin
            if (!TX_DONE) begin
               next_state = WAIT_DONE;
            end else if (cnt == CNT_LAST) begin
               next_err   = 1'b1;
               next_state = IDLE;
            end else begin
               next_dv  = 1'b1;
               next_cnt = cnt + CW'(1);
            end
         end
         WAIT_DONE: begin
            if (TX_DONE) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
            next_ptr   = '0;
            next_cnt   = '0;
            next_byte  = '0;
            next_grant = '0;
         end
      endcase
   end

   always_ff @(posedge SER_CLK) begin
      if (RST) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         REQ_ACK  <= '0;
         TX_DV    <= 1'b0;
         TX_BYTE  <= '0;
         GRANT_ID <= '0;
         BUSY     <= 1'b0;
         ERR      <= 1'b0;
      end else begin
         state    <= next_state;
         ptr      <= next_ptr;
         cnt      <= next_cnt;
         REQ_ACK  <= next_ack;
         TX_DV    <= next_dv;
         TX_BYTE  <= next_byte;
         GRANT_ID <= next_grant;
         BUSY     <= (next_state != IDLE);
         ERR      <= next_err;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural UART (4 clocks per bit) behind it.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ       = 4;
   localparam int START_TIMEOUT = 16;
   localparam int CPB           = 4;

   logic         SER_CLK = 1'b0;
   logic         RST = 1'b1;
   logic [3:0]   REQ_VALID = '0;
   logic [31:0]  REQ_BYTE = '0;
   logic [3:0]   REQ_ACK;
   logic         TX_DV;
   logic [7:0]   TX_BYTE;
   logic         TX_DONE;
   logic [2:0]   GRANT_ID;
   logic         BUSY;
   logic         ERR;

   logic         uart_on = 1'b1;
   logic         ext_done = 1'b1;

   logic [1:0]   u_state = 2'd0;
   logic         u_done = 1'b1;
   logic         u_line = 1'b1;
   logic [9:0]   u_shift = '0;
   logic [7:0]   u_rx = '0;
   int           u_cnt = 0;
   int           u_bit = 0;
   logic [7:0]   frames_q[$];

   int           ack_pulses = 0;
   int           ack_bits = 0;
   int           err_pulses = 0;
   int           ack_order[$];

   int           total = 0;
   int           bad = 0;

   assign TX_DONE = uart_on ? u_done : ext_done;

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .SER_CLK   (SER_CLK),
      .RST       (RST),
      .REQ_VALID (REQ_VALID),
      .REQ_BYTE  (REQ_BYTE),
      .REQ_ACK   (REQ_ACK),
      .TX_DV     (TX_DV),
      .TX_BYTE   (TX_BYTE),
      .TX_DONE   (TX_DONE),
      .GRANT_ID  (GRANT_ID),
      .BUSY      (BUSY),
      .ERR       (ERR)
   );

   always #5 SER_CLK = ~SER_CLK;

   // UART stand-in: latches TX_DV while idle, drops DONE a cycle later, shifts out start/8 data/stop LSB first.
   always @(posedge SER_CLK) begin
      if (!uart_on) begin
         u_state <= 2'd0;
         u_done  <= 1'b1;
         u_line  <= 1'b1;
      end else begin
         case (u_state)
            2'd0: begin
               if (TX_DV === 1'b1) begin
                  u_shift <= {1'b1, TX_BYTE, 1'b0};
                  u_state <= 2'd1;
               end
            end
            2'd1: begin
               u_done  <= 1'b0;
               u_line  <= u_shift[0];
               u_shift <= {1'b1, u_shift[9:1]};
               u_cnt   <= 0;
               u_bit   <= 0;
               u_state <= 2'd2;
            end
            default: begin
               if (u_cnt == CPB - 1) begin
                  u_cnt <= 0;
                  if (u_bit >= 1 && u_bit <= 8) begin
                     u_rx <= {u_line, u_rx[7:1]};
                  end
                  if (u_bit == 9) begin
                     u_done  <= 1'b1;
                     u_line  <= 1'b1;
                     u_state <= 2'd0;
                     frames_q.push_back(u_rx);
                  end else begin
                     u_bit   <= u_bit + 1;
                     u_line  <= u_shift[0];
                     u_shift <= {1'b1, u_shift[9:1]};
                  end
               end else begin
                  u_cnt <= u_cnt + 1;
               end
            end
         endcase
      end
   end

   // Grant and error monitor, sampled away from the active edge.
   always @(negedge SER_CLK) begin
      if (!$isunknown(REQ_ACK) && REQ_ACK != 4'b0000) begin
         ack_pulses <= ack_pulses + 1;
         ack_bits   <= ack_bits + $countones(REQ_ACK);
         for (int i = 0; i < 4; i++) begin
            if (REQ_ACK[i]) ack_order.push_back(i);
         end
      end
      if (ERR === 1'b1) err_pulses <= err_pulses + 1;
   end

   task automatic wait_idle(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge SER_CLK);
         if (BUSY === 1'b0 && TX_DONE === 1'b1) break;
      end
      repeat (3) @(negedge SER_CLK);
   endtask

   // Presents v, returns the acked slot and byte; winner stays -1 on no ack, -2 if it never went idle.
   task automatic run_one(input logic [3:0] v, output int winner, output logic [7:0] got_byte);
      winner   = -1;
      got_byte = 'x;
      REQ_VALID = v;
      for (int i = 0; i < 100 && winner < 0; i++) begin
         @(negedge SER_CLK);
         if (!$isunknown(REQ_ACK) && REQ_ACK != 4'b0000) begin
            for (int j = 3; j >= 0; j--) begin
               if (REQ_ACK[j]) winner = j;
            end
            got_byte = TX_BYTE;
         end
      end
      REQ_VALID = '0;
      for (int i = 0; i < 300; i++) begin
         @(negedge SER_CLK);
         if (BUSY === 1'b0 && TX_DONE === 1'b1) break;
      end
      if (BUSY !== 1'b0) winner = -2;
      repeat (3) @(negedge SER_CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      REQ_VALID = '0;
      repeat (3) @(negedge SER_CLK);
      total++;
      if ({TX_DV, BUSY, ERR} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL reset_ctrl got=%b exp=000", {TX_DV, BUSY, ERR});
      end
      total++;
      if (TX_BYTE !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_byte got=%h exp=00", TX_BYTE);
      end
      total++;
      if (REQ_ACK !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_ack got=%b exp=0000", REQ_ACK);
      end
      total++;
      if (GRANT_ID !== 3'd0) begin
         bad++;
         $display("[TB] FAIL reset_grant got=%0d exp=0", GRANT_ID);
      end
      RST = 1'b0;
      repeat (2) @(negedge SER_CLK);
   endtask

   task automatic test_single();
      int   frames0, acks0;
      bit   done_low;
      bit   dv_late;
      frames0 = frames_q.size();
      acks0   = ack_pulses;
      done_low = 1'b0;
      dv_late  = 1'b0;
      REQ_BYTE[15:8] = 8'hA5;
      REQ_VALID = 4'b0010;
      @(negedge SER_CLK);
      total++;
      if (REQ_ACK !== 4'b0010 || GRANT_ID !== 3'd1) begin
         bad++;
         $display("[TB] FAIL single_grant got ack=%b id=%0d exp ack=0010 id=1", REQ_ACK, GRANT_ID);
      end
      total++;
      if (TX_BYTE !== 8'hA5 || TX_DV !== 1'b0 || BUSY !== 1'b1) begin
         bad++;
         $display("[TB] FAIL single_capture got byte=%h dv=%b busy=%b exp byte=a5 dv=0 busy=1", TX_BYTE, TX_DV, BUSY);
      end
      REQ_VALID = '0;
      @(negedge SER_CLK);
      total++;
      if (REQ_ACK !== 4'b0000 || TX_DV !== 1'b1) begin
         bad++;
         $display("[TB] FAIL single_launch got ack=%b dv=%b exp ack=0000 dv=1", REQ_ACK, TX_DV);
      end
      for (int i = 0; i < 200; i++) begin
         @(negedge SER_CLK);
         if (TX_DONE === 1'b0) done_low = 1'b1;
         if (done_low && TX_DONE === 1'b1 && TX_DV === 1'b1) dv_late = 1'b1;
         if (BUSY === 1'b0) break;
      end
      total++;
      if (BUSY !== 1'b0 || TX_DONE !== 1'b1 || done_low !== 1'b1) begin
         bad++;
         $display("[TB] FAIL single_busy_fall got busy=%b done=%b seen_low=%b exp 0 1 1", BUSY, TX_DONE, done_low);
      end
      total++;
      if (dv_late !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_dv_drop got dv_high_after_done=%b exp=0", dv_late);
      end
      repeat (6) @(negedge SER_CLK);
      total++;
      if (frames_q.size() - frames0 != 1 || ack_pulses - acks0 != 1) begin
         bad++;
         $display("[TB] FAIL single_counts got frames=%0d acks=%0d exp 1 1", frames_q.size() - frames0, ack_pulses - acks0);
      end
      total++;
      if (frames_q.size() <= frames0 || frames_q[frames0] !== 8'hA5) begin
         bad++;
         $display("[TB] FAIL single_serial got=%h exp=a5", (frames_q.size() > frames0) ? frames_q[frames0] : 8'hxx);
      end
   endtask

   task automatic test_simultaneous();
      int         frames0, acks0, bits0, ord0;
      int         exp_ord[5];
      logic [7:0] exp_byte[5];
      exp_ord  = '{0, 1, 2, 3, 0};
      exp_byte = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      RST = 1'b1;
      @(negedge SER_CLK);
      RST = 1'b0;
      @(negedge SER_CLK);
      frames0 = frames_q.size();
      acks0   = ack_pulses;
      bits0   = ack_bits;
      ord0    = ack_order.size();
      REQ_BYTE  = {8'h13, 8'h12, 8'h11, 8'h10};
      REQ_VALID = 4'b1111;
      for (int i = 0; i < 400; i++) begin
         @(negedge SER_CLK);
         if (ack_pulses - acks0 >= 5) break;
      end
      REQ_VALID = '0;
      wait_idle(300);
      total++;
      if (ack_pulses - acks0 != 5 || ack_bits - bits0 != 5) begin
         bad++;
         $display("[TB] FAIL rr_ack_count got pulses=%0d bits=%0d exp 5 5", ack_pulses - acks0, ack_bits - bits0);
      end
      total++;
      if (frames_q.size() - frames0 != 5) begin
         bad++;
         $display("[TB] FAIL rr_frame_count got=%0d exp=5", frames_q.size() - frames0);
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (ack_order.size() <= ord0 + i || ack_order[ord0 + i] != exp_ord[i]) begin
            bad++;
            $display("[TB] FAIL rr_order[%0d] got=%0d exp=%0d", i, (ack_order.size() > ord0 + i) ? ack_order[ord0 + i] : -1, exp_ord[i]);
         end
         total++;
         if (frames_q.size() <= frames0 + i || frames_q[frames0 + i] !== exp_byte[i]) begin
            bad++;
            $display("[TB] FAIL rr_byte[%0d] got=%h exp=%h", i, (frames_q.size() > frames0 + i) ? frames_q[frames0 + i] : 8'hxx, exp_byte[i]);
         end
      end
   endtask

   task automatic test_pointer_wrap();
      int         w;
      logic [7:0] b;
      REQ_BYTE = {8'h33, 8'h42, 8'h21, 8'h40};
      run_one(4'b1000, w, b);
      total++;
      if (w != 3 || b !== 8'h33) begin
         bad++;
         $display("[TB] FAIL wrap_setup got slot=%0d byte=%h exp slot=3 byte=33", w, b);
      end
      run_one(4'b0101, w, b);
      total++;
      if (w != 0 || b !== 8'h40) begin
         bad++;
         $display("[TB] FAIL wrap_to_zero got slot=%0d byte=%h exp slot=0 byte=40", w, b);
      end
      run_one(4'b0100, w, b);
      total++;
      if (w != 2 || b !== 8'h42) begin
         bad++;
         $display("[TB] FAIL wrap_next got slot=%0d byte=%h exp slot=2 byte=42", w, b);
      end
   endtask

   task automatic test_stuck_done();
      int   acks0, errs0, err_k;
      logic dv_at_err, busy_at_err;
      int   dv_early;
      uart_on  = 1'b0;
      ext_done = 1'b1;
      @(negedge SER_CLK);
      acks0 = ack_pulses;
      errs0 = err_pulses;
      err_k = -1;
      dv_early = 0;
      dv_at_err = 1'bx;
      busy_at_err = 1'bx;
      REQ_BYTE[15:8] = 8'h77;
      REQ_VALID = 4'b0010;
      @(negedge SER_CLK);
      total++;
      if (REQ_ACK !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL stuck_grant got=%b exp=0010", REQ_ACK);
      end
      REQ_VALID = '0;
      @(negedge SER_CLK);
      total++;
      if (TX_DV !== 1'b1) begin
         bad++;
         $display("[TB] FAIL stuck_launch got dv=%b exp=1", TX_DV);
      end
      for (int k = 1; k <= 30; k++) begin
         @(negedge SER_CLK);
         if (err_k < 0 && ERR === 1'b1) begin
            err_k       = k;
            dv_at_err   = TX_DV;
            busy_at_err = BUSY;
         end else if (err_k < 0 && TX_DV !== 1'b1) begin
            dv_early++;
         end
      end
      total++;
      if (err_k != 16) begin
         bad++;
         $display("[TB] FAIL stuck_err_time got=%0d exp=16", err_k);
      end
      total++;
      if (dv_at_err !== 1'b0 || busy_at_err !== 1'b0 || dv_early != 0) begin
         bad++;
         $display("[TB] FAIL stuck_abort got dv=%b busy=%b early_drops=%0d exp 0 0 0", dv_at_err, busy_at_err, dv_early);
      end
      total++;
      if (err_pulses - errs0 != 1 || ack_pulses - acks0 != 1) begin
         bad++;
         $display("[TB] FAIL stuck_pulses got err=%0d ack=%0d exp 1 1", err_pulses - errs0, ack_pulses - acks0);
      end
      uart_on = 1'b1;
      repeat (2) @(negedge SER_CLK);
   endtask

   task automatic test_reset_mid_frame();
      int frames0, acks0, early_ack;
      bit got;
      frames0 = frames_q.size();
      early_ack = 0;
      got = 1'b0;
      REQ_BYTE[7:0] = 8'h5C;
      REQ_VALID = 4'b0001;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge SER_CLK);
         if (REQ_ACK === 4'b0001) got = 1'b1;
      end
      REQ_VALID = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge SER_CLK);
         if (TX_DONE === 1'b0) break;
      end
      repeat (3) @(negedge SER_CLK);
      REQ_BYTE  = {8'h33, 8'h62, 8'h21, 8'h60};
      REQ_VALID = 4'b0101;
      RST = 1'b1;
      @(negedge SER_CLK);
      RST = 1'b0;
      total++;
      if ({TX_DV, BUSY, ERR, REQ_ACK, GRANT_ID, TX_BYTE} !== '0) begin
         bad++;
         $display("[TB] FAIL midrst_outputs got dv=%b busy=%b err=%b ack=%b id=%0d byte=%h exp all 0", TX_DV, BUSY, ERR, REQ_ACK, GRANT_ID, TX_BYTE);
      end
      acks0 = ack_pulses;
      for (int i = 0; i < 100; i++) begin
         @(negedge SER_CLK);
         if (TX_DONE === 1'b1) break;
         if (REQ_ACK !== 4'b0000) early_ack++;
      end
      total++;
      if (early_ack != 0 || ack_pulses - acks0 != 0) begin
         bad++;
         $display("[TB] FAIL midrst_no_grant got early=%0d acks=%0d exp 0 0", early_ack, ack_pulses - acks0);
      end
      @(negedge SER_CLK);
      total++;
      if (REQ_ACK !== 4'b0001 || GRANT_ID !== 3'd0 || TX_BYTE !== 8'h60) begin
         bad++;
         $display("[TB] FAIL midrst_regrant got ack=%b id=%0d byte=%h exp ack=0001 id=0 byte=60", REQ_ACK, GRANT_ID, TX_BYTE);
      end
      REQ_VALID = '0;
      wait_idle(300);
      total++;
      if (frames_q.size() - frames0 != 2 || frames_q[frames0] !== 8'h5C || frames_q[frames0 + 1] !== 8'h60) begin
         bad++;
         $display("[TB] FAIL midrst_frames got count=%0d exp 2 frames 5c,60", frames_q.size() - frames0);
      end
   endtask

   task automatic test_hold_done_low();
      int early_ack;
      early_ack = 0;
      uart_on  = 1'b0;
      ext_done = 1'b0;
      REQ_BYTE[15:8] = 8'h99;
      REQ_VALID = 4'b0010;
      repeat (10) begin
         @(negedge SER_CLK);
         if (REQ_ACK !== 4'b0000) early_ack++;
      end
      total++;
      if (early_ack != 0 || BUSY !== 1'b0) begin
         bad++;
         $display("[TB] FAIL hold_no_grant got early=%0d busy=%b exp 0 0", early_ack, BUSY);
      end
      ext_done = 1'b1;
      @(negedge SER_CLK);
      total++;
      if (REQ_ACK !== 4'b0010 || GRANT_ID !== 3'd1 || TX_BYTE !== 8'h99) begin
         bad++;
         $display("[TB] FAIL hold_release got ack=%b id=%0d byte=%h exp ack=0010 id=1 byte=99", REQ_ACK, GRANT_ID, TX_BYTE);
      end
      REQ_VALID = '0;
      wait_idle(60);
      uart_on = 1'b1;
      repeat (2) @(negedge SER_CLK);
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_pointer_wrap();
      test_stuck_done();
      test_reset_mid_frame();
      test_hold_done_low();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter among `NUM_REQ` byte sources. Each requester presents a byte with a valid flag; the arbiter selects one, launches it with the UART's `TX_DV`/`TX_BYTE` handshake, and tracks the UART's `DONE` through the whole frame. It then grants the next requester. The block sits between the on-chip message sources (status reporter, debug dumper, etc.) and the single `uart_tx` instance driving the board serial line.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `START_TIMEOUT`, 16: cycles to wait for `TX_DONE` to fall after launch before aborting.

Ports:
- `SER_CLK`  in  1  system clock; all logic on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `REQ_VALID`  in  NUM_REQ  bit i high means requester i has a byte pending.
- `REQ_BYTE`  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- `REQ_ACK`  out  NUM_REQ  one-cycle pulse on bit i when requester i's byte is captured; the requester then advances its data.
- `TX_DV`  out  1  to UART `TX_DV`.
- `TX_BYTE`  out  8  to UART `TX_BYTE`.
- `TX_DONE`  in  1  from UART `DONE`: high when idle, low while a frame is in flight.
- `GRANT_ID`  out  3  index of the current or last granted requester.
- `BUSY`  out  1  high whenever the state is not IDLE.
- `ERR`  out  1  one-cycle pulse on a start timeout.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If `TX_DONE`=1 and any `REQ_VALID` bit is set, choose the winner by round-robin, starting the search at `ptr` (next index after the last winner, modulo `NUM_REQ`).
  - Capture the winner's byte into `TX_BYTE`, set `GRANT_ID`, and pulse `REQ_ACK[winner]`.
  - Set `ptr` to winner+1, wrapping `NUM_REQ-1` to 0, then go to LAUNCH.
  - If `TX_DONE`=0, stay in IDLE and grant nothing.
- **LAUNCH**: drive `TX_DV`=1, clear the timeout counter, go to WAIT_BUSY.
- **WAIT_BUSY**
  - Hold `TX_DV`=1 and keep `TX_BYTE` stable.
  - When `TX_DONE`=0 is sampled, drop `TX_DV` and go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `START_TIMEOUT`-1, drop `TX_DV`, pulse `ERR`, and go to IDLE. The requester is not re-acked; that byte is lost.
- **WAIT_DONE**: `TX_DV`=0, `TX_BYTE` held. When `TX_DONE`=1 is sampled, go to IDLE.
- `TX_DV` must be low before the UART's DONE returns high. This prevents the UART from re-latching `TX_DV` and sending a duplicate frame.
- `REQ_VALID` changes after capture have no effect on the frame in flight.
- Undefined state encodings go to IDLE with all outputs at their reset values.
- Reset values: `TX_DV`=0, `TX_BYTE`=0, `REQ_ACK`=0, `GRANT_ID`=0, `BUSY`=0, `ERR`=0, `ptr`=0 (requester 0 has first priority), state IDLE.

## Timing
- All outputs are registered.
- Grant latency: `REQ_VALID` sampled high in IDLE at edge N gives `REQ_ACK` and `TX_BYTE` valid after edge N and `TX_DV` high after edge N+1.
- `TX_DV` stays high for at least 2 cycles, until DONE falls. The UART's latch delay makes DONE fall roughly 3 cycles after `TX_DV` rises.
- Frame occupancy is about 10·CLKS_PER_BIT of the UART plus 2 cleanup cycles.
- The next grant comes no earlier than the first IDLE cycle in which `TX_DONE`=1, i.e. 1 cycle after WAIT_DONE exits.
- Simultaneous requests are served in round-robin order. No requester waits more than `NUM_REQ`-1 frames while continuously valid.
- `RST` asserted in any state, including mid-frame:
  - outputs take their reset values on the next edge;
  - the UART finishes its current frame independently;
  - the arbiter does not grant again until `TX_DONE`=1.
- `RST` has priority over all state transitions.

## Test plan
- **Single request:** `REQ_VALID`=4'b0010, byte 8'hA5 on slot 1, `TX_DONE` from a real `uart_tx` (CLKS_PER_BIT=4).
  - `REQ_ACK`=4'b0010 for exactly 1 cycle, `GRANT_ID`=1.
  - Serial line shows 0xA5 once, LSB first.
  - `BUSY` falls after DONE returns high.
- **Simultaneous requests:** all four valid, bytes 8'h10/8'h11/8'h12/8'h13, valid held continuously.
  - Frames go out in order 0,1,2,3,0,…
  - Exactly one `REQ_ACK` pulse per frame and no duplicate frames.
- **Pointer wrap:** last winner 3; requesters 0 and 2 both valid → 0 wins. Next request from 2 alone → 2 wins.
- **Stuck DONE:** tie `TX_DONE`=1 (no UART), `START_TIMEOUT`=16.
  - `ERR` pulses once 16 cycles after LAUNCH.
  - `TX_DV` drops in the same cycle, state returns to IDLE, and `REQ_ACK` is not repeated.
- **Reset mid-frame:** assert `RST` for 1 cycle during WAIT_DONE.
  - All outputs are 0 on the next cycle.
  - No grant while `TX_DONE`=0.
  - The pending requester is granted after DONE rises, with `ptr`=0 priority.
- **Hold `TX_DONE` low in IDLE:** assert requests while the UART is still busy from an external source. No `REQ_ACK` until `TX_DONE`=1.
